mpu_matrix_streamer: RTL and testbench

- Reads a flattened 5x5 matrix of 8-bit elements, as produced by the MPU element-wise units (e.g. the add result bus), and streams it out one element per beat.
- Consumer side of the parallel matrix bus: converts the wide parallel result into a narrow valid/ready element stream for downstream writeback or host readout.
- Holds one captured matrix and supports back-to-back matrices with no bubble.

---
 rtl/mpu_matrix_streamer_if.sv | 47 ++++
 rtl/mpu_matrix_streamer.sv | 119 +++++++++++
 tb/tb_mpu_matrix_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_matrix_streamer_if.sv
// Bus bundle between a parallel matrix producer, the matrix streamer and the
// downstream element consumer. The streamer takes the slave view; whatever
// drives the matrix and consumes the elements takes the master view.
interface mpu_matrix_streamer_if #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 3
);

  logic [ELEM_W*DIM*DIM-1:0] in_matrix;
  logic                      in_valid;
  logic                      in_ready;
  logic [ELEM_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_row;
  logic [IDX_W-1:0]          out_col;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport slave (
    input  in_matrix,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    output out_valid,
    input  out_ready,
    output busy
  );

  modport master (
    output in_matrix,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    input  out_valid,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/mpu_matrix_streamer.sv
// Matrix streamer: captures one flattened DIM x DIM matrix from the parallel
// result bus and replays it as a valid/ready stream of single elements in
// row-major order. The final beat of a matrix can capture the next one in the
// same edge, so consecutive matrices stream with no idle cycle between them.
module mpu_matrix_streamer #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpu_matrix_streamer_if.slave bus
);

  localparam int NUM_ELEMS = DIM * DIM;
  localparam int FLAT_W    = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_nextState;
  logic [ELEM_W*NUM_ELEMS-1:0] r_buffer;
  logic [IDX_W-1:0]            r_row;
  logic [IDX_W-1:0]            r_col;

  logic [ELEM_W-1:0]           w_elems [NUM_ELEMS];
  logic [FLAT_W-1:0]           w_flatIdx;
  logic                        w_atLast;
  logic                        w_outValid;
  logic                        w_inReady;
  logic                        w_busy;
  logic                        w_beat;
  logic                        w_capture;

  // The held matrix is column-major in the flat vector: element (i,j) sits at
  // slot i + DIM*j. Unpacking it once keeps the element mux a plain index.
  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_unpack
    assign w_elems[k] = r_buffer[ELEM_W*k +: ELEM_W];
  end

  assign w_flatIdx = FLAT_W'(r_row) + FLAT_W'(FLAT_W'(DIM) * FLAT_W'(r_col));
  assign w_atLast  = (r_row == LAST_IDX) && (r_col == LAST_IDX);
  assign w_beat    = w_outValid && bus.out_ready;
  assign w_capture = bus.in_valid && w_inReady;

  // State register; reset drops any partially streamed matrix immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs. in_ready opens in STREAM only while the
  // final element is being accepted, which is what makes back-to-back work.
  always_comb begin
    w_nextState = r_state;
    w_outValid  = 1'b0;
    w_inReady   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_nextState = STREAM;
        end
      end
      STREAM: begin
        w_outValid = 1'b1;
        w_busy     = 1'b1;
        w_inReady  = w_atLast && bus.out_ready;
        if (w_atLast && bus.out_ready && !bus.in_valid) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Matrix buffer and row/column walk. Indices return to (0,0) after the last
  // element, so they never wrap past the end of the matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buffer <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else if (w_capture) begin
      r_buffer <= bus.in_matrix;
      r_row    <= '0;
      r_col    <= '0;
    end else if (w_beat) begin
      if (w_atLast) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= r_row + IDX_W'(1);
      end else begin
        r_col <= r_col + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.out_row   = r_row;
  assign bus.out_col   = r_col;
  assign bus.out_last  = w_outValid && w_atLast;
  assign bus.out_data  = w_elems[w_flatIdx];

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Bench for the matrix streamer: an expected-element queue model checks every
// cycle, a table of known elements checks the first stream, and directed
// sequences cover stalls, back-to-back loads, mid-stream requests and reset.
module tb_mpu_matrix_streamer;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int IDX_W  = 3;
  localparam int NUM    = DIM * DIM;
  localparam int MAT_W  = ELEM_W * NUM;

  typedef struct {
    logic [ELEM_W-1:0] data;
    int                row;
    int                col;
    bit                last;
    int                cyc;
  } elem_t;

  typedef struct {
    int                beat;
    logic [ELEM_W-1:0] expData;
    int                expRow;
    int                expCol;
    bit                expLast;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mpu_matrix_streamer_if #(.DIM(DIM), .ELEM_W(ELEM_W), .IDX_W(IDX_W)) bus ();

  mpu_matrix_streamer #(.DIM(DIM), .ELEM_W(ELEM_W), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    errors   = 0;
  int    cycleCnt = 0;
  elem_t modelQ[$];
  elem_t beatLog[$];
  elem_t monElem;
  bit    mBeat;
  bit    mCap;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Element number n of the row-major stream, taken straight from the
  // flattened layout where (i,j) lives at slot i + DIM*j.
  function automatic elem_t elemAt(input logic [MAT_W-1:0] m, input int n);
    elem_t e;
    e.row  = n / DIM;
    e.col  = n % DIM;
    e.data = m[ELEM_W*(e.row + DIM*e.col) +: ELEM_W];
    e.last = (n == NUM - 1);
    e.cyc  = 0;
    return e;
  endfunction

  // mode 0: {1..25} with 1 in the MSBs, 1: {25..1}, 2: all 0xFF, 3: random
  function automatic logic [MAT_W-1:0] buildMatrix(input int mode);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < NUM; k++) begin
      case (mode)
        0:       m[ELEM_W*k +: ELEM_W] = ELEM_W'(NUM - k);
        1:       m[ELEM_W*k +: ELEM_W] = ELEM_W'(k + 1);
        2:       m[ELEM_W*k +: ELEM_W] = '1;
        default: m[ELEM_W*k +: ELEM_W] = ELEM_W'($urandom);
      endcase
    end
    return m;
  endfunction

  always @(posedge clk) cycleCnt++;

  // Reference model: a queue of the elements still owed to the consumer.
  // A beat pops one; an accepted matrix appends all DIM*DIM of its elements.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
    end else begin
      mBeat = (modelQ.size() > 0) && bus.out_ready;
      mCap  = bus.in_valid && ((modelQ.size() == 0) ||
                               ((modelQ.size() == 1) && bus.out_ready));
      if (mBeat) void'(modelQ.pop_front());
      if (mCap) begin
        for (int n = 0; n < NUM; n++) modelQ.push_back(elemAt(bus.in_matrix, n));
      end
    end
  end

  // Mid-cycle monitor: compares every output with the model and logs beats.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(modelQ.size() > 0));
      checkOutput("busy", 32'(bus.busy), 32'(modelQ.size() > 0));
      checkOutput("in_ready", 32'(bus.in_ready),
                  32'((modelQ.size() == 0) || ((modelQ.size() == 1) && bus.out_ready)));
      if (modelQ.size() > 0) begin
        checkOutput("out_data", 32'(bus.out_data), 32'(modelQ[0].data));
        checkOutput("out_row", 32'(bus.out_row), 32'(modelQ[0].row));
        checkOutput("out_col", 32'(bus.out_col), 32'(modelQ[0].col));
        checkOutput("out_last", 32'(bus.out_last), 32'(modelQ[0].last));
      end
      if (bus.out_valid && bus.out_ready) begin
        monElem.data = bus.out_data;
        monElem.row  = int'(bus.out_row);
        monElem.col  = int'(bus.out_col);
        monElem.last = bus.out_last;
        monElem.cyc  = cycleCnt;
        beatLog.push_back(monElem);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [MAT_W-1:0] m, input logic v, input logic rdy);
    bus.in_matrix = m;
    bus.in_valid  = v;
    bus.out_ready = rdy;
  endtask

  task automatic loadMatrix(input logic [MAT_W-1:0] m);
    beatLog.delete();
    applyStimulus(m, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Runs until n beats are logged; stall mode drives out_ready as 1,0,0,1.
  task automatic waitBeats(input int n, input int budget, input bit stall);
    int cnt = 0;
    while (beatLog.size() < n && cnt < budget) begin
      if (stall) bus.out_ready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
      tick();
      cnt++;
    end
    bus.out_ready = 1'b1;
    checkOutput("beatsReached", 32'(beatLog.size() >= n), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int cnt = 0;
    while (bus.busy && cnt < budget) begin
      tick();
      cnt++;
    end
    checkOutput("idleBusy", 32'(bus.busy), 32'd0);
    checkOutput("idleInReady", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic compareLog(input logic [MAT_W-1:0] m, input string tag);
    elem_t e;
    checkOutput({tag, "_count"}, 32'(beatLog.size()), 32'(NUM));
    for (int n = 0; n < NUM && n < beatLog.size(); n++) begin
      e = elemAt(m, n);
      checkOutput({tag, "_data"}, 32'(beatLog[n].data), 32'(e.data));
      checkOutput({tag, "_index"}, 32'(beatLog[n].row * DIM + beatLog[n].col), 32'(n));
    end
  endtask

  vec_t vecs[8];

  task automatic checkTable(input string tag);
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].beat < beatLog.size()) begin
        checkOutput({tag, "_tdata"}, 32'(beatLog[vecs[v].beat].data), 32'(vecs[v].expData));
        checkOutput({tag, "_trow"}, 32'(beatLog[vecs[v].beat].row), 32'(vecs[v].expRow));
        checkOutput({tag, "_tcol"}, 32'(beatLog[vecs[v].beat].col), 32'(vecs[v].expCol));
        checkOutput({tag, "_tlast"}, 32'(beatLog[vecs[v].beat].last), 32'(vecs[v].expLast));
      end else begin
        checkOutput({tag, "_tmissing"}, 32'(beatLog.size()), 32'(vecs[v].beat + 1));
      end
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lasts;
    int pulses;
    int pulseBeat;
    int cnt;
    bit sawReady;
    logic [MAT_W-1:0] asc;
    logic [MAT_W-1:0] desc;
    logic [MAT_W-1:0] ones;

    // Known elements of the {1..25} stream; (i,j) holds 25 - i - 5*j.
    vecs[0] = '{0,  8'd25, 0, 0, 1'b0};
    vecs[1] = '{1,  8'd20, 0, 1, 1'b0};
    vecs[2] = '{4,  8'd5,  0, 4, 1'b0};
    vecs[3] = '{5,  8'd24, 1, 0, 1'b0};
    vecs[4] = '{12, 8'd13, 2, 2, 1'b0};
    vecs[5] = '{20, 8'd21, 4, 0, 1'b0};
    vecs[6] = '{23, 8'd6,  4, 3, 1'b0};
    vecs[7] = '{24, 8'd1,  4, 4, 1'b1};

    asc  = buildMatrix(0);
    desc = buildMatrix(1);
    ones = buildMatrix(2);

    applyStimulus('0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_row", 32'(bus.out_row), 32'd0);
    checkOutput("rst_col", 32'(bus.out_col), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] ascending matrix, no backpressure");
    loadMatrix(asc);
    waitBeats(NUM, 60, 1'b0);
    checkTable("plain");
    lasts = 0;
    foreach (beatLog[n]) if (beatLog[n].last) lasts++;
    checkOutput("plain_lastCount", 32'(lasts), 32'd1);
    tick();
    waitIdle(10);

    $display("[TB] ascending matrix with 1,0,0,1 backpressure");
    loadMatrix(asc);
    waitBeats(NUM, 200, 1'b1);
    checkTable("stall");
    compareLog(asc, "stall");
    tick();
    waitIdle(10);

    $display("[TB] back-to-back matrices");
    loadMatrix(asc);
    applyStimulus(desc, 1'b1, 1'b1);
    pulses    = 0;
    pulseBeat = -1;
    cnt       = 0;
    while (beatLog.size() < 2 * NUM && cnt < 150) begin
      sawReady = bus.in_ready && bus.in_valid;
      if (sawReady) begin
        pulses++;
        pulseBeat = beatLog.size();
      end
      tick();
      if (sawReady) bus.in_valid = 1'b0;
      cnt++;
    end
    checkOutput("b2b_beats", 32'(beatLog.size()), 32'(2 * NUM));
    checkOutput("b2b_pulses", 32'(pulses), 32'd1);
    checkOutput("b2b_pulseBeat", 32'(pulseBeat), 32'(NUM - 1));
    if (beatLog.size() >= 2 * NUM) begin
      checkOutput("b2b_gapless", 32'(beatLog[2*NUM-1].cyc - beatLog[0].cyc), 32'(2 * NUM - 1));
      checkOutput("b2b_firstLast", 32'(beatLog[NUM-1].last), 32'd1);
      checkOutput("b2b_secondData", 32'(beatLog[NUM].data), 32'd1);
      checkOutput("b2b_secondIdx", 32'(beatLog[NUM].row * DIM + beatLog[NUM].col), 32'd0);
      checkOutput("b2b_finalData", 32'(beatLog[2*NUM-1].data), 32'd25);
    end
    tick();
    waitIdle(10);

    $display("[TB] new matrix offered mid-stream");
    loadMatrix(asc);
    waitBeats(10, 40, 1'b0);
    applyStimulus(desc, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("mid_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    waitBeats(NUM, 40, 1'b0);
    compareLog(asc, "mid");
    tick();
    waitIdle(10);

    $display("[TB] reset during stream");
    loadMatrix(asc);
    waitBeats(7, 40, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_row", 32'(bus.out_row), 32'd0);
    checkOutput("abort_col", 32'(bus.out_col), 32'd0);
    checkOutput("abort_out_last", 32'(bus.out_last), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    loadMatrix(desc);
    waitBeats(NUM, 40, 1'b0);
    compareLog(desc, "fresh");
    tick();
    waitIdle(10);

    $display("[TB] all-ones matrix");
    loadMatrix(ones);
    waitBeats(NUM, 40, 1'b0);
    compareLog(ones, "ones");
    tick();
    waitIdle(10);

    $display("[TB] randomized traffic against the model");
    for (int c = 0; c < 600; c++) begin
      applyStimulus(buildMatrix(3), 1'(($urandom % 10) < 3), 1'(($urandom % 10) < 7));
      tick();
    end
    applyStimulus('0, 1'b0, 1'b1);
    waitIdle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
